key_conditioner: RTL and testbench

- Front-end input stage that sits directly upstream of the free-play mode block.
- Takes the 8 raw note keys and the 3 raw navigation buttons (up/center/down) from the board pins.
- Synchronizes and debounces every input.
- Drives clean note levels plus single-cycle navigation pulses, so octave selection fires exactly once per physical press.

---
 rtl/key_conditioner.sv | 79 +++++++
 tb/tb_key_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Input front end: two-flop sync plus debounce for note keys and nav buttons.
// Delivers stable key levels and single-cycle press pulses for navigation.
module key_conditioner #(
    parameter int N_KEYS    = 8,
    parameter int DB_CYCLES = 2000000,
    parameter int CNT_W     = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic              up_raw,
    input  logic              center_raw,
    input  logic              down_raw,
    output logic [N_KEYS-1:0] buts,
    output logic              but_up,
    output logic              but_center,
    output logic              but_down,
    output logic              any_key
);

    localparam int NCH = N_KEYS + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1_q;
    logic [NCH-1:0]   s2_q;
    logic [NCH-1:0]   st_q;
    logic [NCH-1:0]   st_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [2:0]       nav_q;
    logic             any_q;

    // Nav buttons occupy the top three channels: up, center, down.
    assign raw = {down_raw, center_raw, up_raw, key_raw};

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = '0;
            if (s2_q[i] != st_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    st_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            st_q  <= '0;
            nav_q <= '0;
            any_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q  <= raw;
            s2_q  <= s1_q;
            st_q  <= st_d;
            nav_q <= st_d[NCH-1:N_KEYS] & ~st_q[NCH-1:N_KEYS];
            any_q <= |st_d[N_KEYS-1:0];
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign buts       = st_q[N_KEYS-1:0];
    assign but_up     = nav_q[0];
    assign but_center = nav_q[1];
    assign but_down   = nav_q[2];
    assign any_key    = any_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus randomized bouncing
// inputs checked every cycle against a sliding-window debounce model.
module tb_key_conditioner;

    localparam int N   = 8;
    localparam int DB  = 4;
    localparam int NCH = N + 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] key_raw;
    logic         up_raw, center_raw, down_raw;
    logic [N-1:0] buts;
    logic         but_up, but_center, but_down, any_key;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    key_conditioner #(.N_KEYS(N), .DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .key_raw(key_raw),
        .up_raw(up_raw), .center_raw(center_raw), .down_raw(down_raw),
        .buts(buts), .but_up(but_up), .but_center(but_center),
        .but_down(but_down), .any_key(any_key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h @%0t",
                      name, act, req, $time);
    endtask

    // Reference model: a channel flips once its last DB synchronized
    // samples all disagree with the stable value.
    logic [NCH-1:0] m_s1 = '0, m_s2 = '0, m_st = '0;
    logic [DB-1:0]  win [NCH];
    int             fill [NCH];
    logic [2:0]     m_pulse = '0;
    logic           m_any = 1'b0;

    initial begin
        logic [NCH-1:0] old;
        for (int c = 0; c < NCH; c++) begin
            win[c]  = '0;
            fill[c] = 0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                m_s1 = '0; m_s2 = '0; m_st = '0;
                m_pulse = '0; m_any = 1'b0;
                for (int c = 0; c < NCH; c++) fill[c] = 0;
            end else begin
                old = m_st;
                for (int c = 0; c < NCH; c++) begin
                    win[c] = {win[c][DB-2:0], m_s2[c]};
                    if (fill[c] < DB) fill[c]++;
                    if (fill[c] == DB && win[c] == {DB{~m_st[c]}}) begin
                        m_st[c] = ~m_st[c];
                        fill[c] = 0;
                    end
                end
                m_pulse = m_st[NCH-1:N] & ~old[NCH-1:N];
                m_any   = |m_st[N-1:0];
                m_s2    = m_s1;
                m_s1    = {down_raw, center_raw, up_raw, key_raw};
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("m_buts", 32'(buts), 32'(m_st[N-1:0]));
                chk("m_up", 32'(but_up), 32'(m_pulse[0]));
                chk("m_center", 32'(but_center), 32'(m_pulse[1]));
                chk("m_down", 32'(but_down), 32'(m_pulse[2]));
                chk("m_any", 32'(any_key), 32'(m_any));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int pr;
        logic [NCH-1:0] r;
        rst = 1'b1; key_raw = '0;
        up_raw = 1'b0; center_raw = 1'b0; down_raw = 1'b0;
        step(); step();
        chk("reset_buts", 32'(buts), 32'h0);
        chk("reset_any", 32'(any_key), 32'h0);
        chk("reset_nav", 32'({but_up, but_center, but_down}), 32'h0);
        rst = 1'b0;
        cmp_en = 1'b1;
        step();

        // Clean press of key 3
        key_raw[3] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("press_buts", 32'(buts), (e >= 6) ? 32'h08 : 32'h0);
            chk("press_any", 32'(any_key), (e >= 6) ? 32'h1 : 32'h0);
        end

        // Bounce on key 0: high 3, low 1, then held
        key_raw[0] = 1'b1;
        step(); step(); step();
        key_raw[0] = 1'b0;
        step();
        key_raw[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("bounce_b0", 32'(buts[0]), (e >= 6) ? 32'h1 : 32'h0);
        end

        // Up held for 50 cycles, then released
        up_raw = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            step();
            chk("nav_up", 32'(but_up), (e == 6) ? 32'h1 : 32'h0);
            chk("nav_cd", 32'({but_center, but_down}), 32'h0);
        end
        up_raw = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk("nav_rel", 32'({but_up, but_center, but_down}), 32'h0);
        end

        // Up and down together
        up_raw = 1'b1; down_raw = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            chk("simul", 32'({but_up, but_down}), (e == 6) ? 32'h3 : 32'h0);
        end
        up_raw = 1'b0; down_raw = 1'b0;
        repeat (8) step();

        // Release keys 0 and 3
        key_raw = '0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("rel_buts", 32'(buts), (e >= 6) ? 32'h0 : 32'h09);
            chk("rel_any", 32'(any_key), (e >= 6) ? 32'h0 : 32'h1);
        end

        // Reset mid-debounce on key 5 and center
        key_raw[5] = 1'b1; center_raw = 1'b1;
        step(); step(); step();
        rst = 1'b1;
        step();
        chk("rst_mid", 32'(buts), 32'h0);
        rst = 1'b0;
        pr = 0;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (but_center) pr++;
            chk("rst_b5", 32'(buts[5]), (e >= 6) ? 32'h1 : 32'h0);
        end
        chk("rst_center_pulses", 32'(pr), 32'h1);

        // Release key 7 after a hold
        key_raw = 8'h80; center_raw = 1'b0;
        repeat (10) step();
        chk("k7_held", 32'(buts), 32'h80);
        key_raw = '0;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("k7_rel", 32'(buts[7]), (e >= 6) ? 32'h0 : 32'h1);
            chk("k7_any", 32'(any_key), (e >= 6) ? 32'h0 : 32'h1);
            chk("k7_nav", 32'({but_up, but_center, but_down}), 32'h0);
        end

        // Randomized bouncing with occasional reset
        pr = 8;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: pr = 2;
                    1: pr = 8;
                    default: pr = 30;
                endcase
            end
            rst = ($urandom_range(0, 299) == 0);
            r = {down_raw, center_raw, up_raw, key_raw};
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, pr - 1) == 0) r[c] = ~r[c];
            end
            {down_raw, center_raw, up_raw, key_raw} = r;
            step();
        end
        rst = 1'b0;
        repeat (12) step();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
